// File: rtl/imm_gen_stage_if.sv
// Decode-to-ID/EX handshake bundle for the immediate stage.
// Optional IN_PC/TARGET lanes exist only when IMM_TARGET_EN is defined.
interface imm_gen_stage_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic              IN_VALID;
    logic              IN_READY;
    logic [31:0]       INSTRUCTION;
    logic [2:0]        IMM_PICK;
    logic [TAG_W-1:0]  IN_TAG;
    logic              OUT_VALID;
    logic              OUT_READY;
    logic [XLEN-1:0]   IMMEDIATE;
    logic [2:0]        OUT_SEL;
    logic [TAG_W-1:0]  OUT_TAG;
`ifdef IMM_TARGET_EN
    logic [XLEN-1:0]   IN_PC;
    logic [XLEN-1:0]   TARGET;

    modport master (
        output IN_VALID, INSTRUCTION, IMM_PICK,
        output IN_TAG, IN_PC, OUT_READY,
        input  IN_READY, OUT_VALID, IMMEDIATE,
        input  OUT_SEL, OUT_TAG, TARGET
    );

    modport slave (
        input  IN_VALID, INSTRUCTION, IMM_PICK,
        input  IN_TAG, IN_PC, OUT_READY,
        output IN_READY, OUT_VALID, IMMEDIATE,
        output OUT_SEL, OUT_TAG, TARGET
    );
`else
    modport master (
        output IN_VALID, INSTRUCTION, IMM_PICK,
        output IN_TAG, OUT_READY,
        input  IN_READY, OUT_VALID, IMMEDIATE,
        input  OUT_SEL, OUT_TAG
    );

    modport slave (
        input  IN_VALID, INSTRUCTION, IMM_PICK,
        input  IN_TAG, OUT_READY,
        output IN_READY, OUT_VALID, IMMEDIATE,
        output OUT_SEL, OUT_TAG
    );
`endif
endinterface

// File: rtl/imm_gen_stage.sv
// Registered immediate generator with a 2-entry skid buffer.
// Define IMM_TARGET_EN to add the PC+immediate TARGET lane.
module imm_gen_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input logic              CLK,
    input logic              RESET_N,
    input logic              FLUSH,
    imm_gen_stage_if.slave   bus
);
    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       sel;
        logic [TAG_W-1:0] tag;
`ifdef IMM_TARGET_EN
        logic [XLEN-1:0]  tgt;
`endif
    } ent_t;

    logic [31:0]     ins;
    logic [6:0]      unused_opcode;
    logic [XLEN-1:0] dec;
    ent_t            nxt;
    ent_t            m;
    ent_t            s;
    logic            m_valid;
    logic            s_valid;
    logic            in_fire;
    logic            out_fire;

    assign ins           = bus.INSTRUCTION;
    assign unused_opcode = ins[6:0];

    always_comb begin
        dec = '0;
        unique case (bus.IMM_PICK)
            3'b000: dec = XLEN'($signed(ins[31:20]));
            3'b001: dec = XLEN'($signed({ins[31:25], ins[11:7]}));
            3'b010: dec = XLEN'($signed({ins[31:12], 12'b0}));
            3'b011: dec = XLEN'($signed({ins[31], ins[7],
                                         ins[30:25], ins[11:8],
                                         1'b0}));
            3'b100: dec = XLEN'($signed({ins[31], ins[19:12],
                                         ins[20], ins[30:21],
                                         1'b0}));
            3'b101: dec = XLEN'(ins[19:15]);
            3'b110: dec = (XLEN == 64) ? XLEN'(ins[25:20])
                                       : XLEN'(ins[24:20]);
            default: dec = '0;
        endcase
    end

    always_comb begin
        nxt     = '0;
        nxt.imm = dec;
        nxt.sel = bus.IMM_PICK;
        nxt.tag = bus.IN_TAG;
`ifdef IMM_TARGET_EN
        nxt.tgt = bus.IN_PC + dec;
`endif
    end

    // Ready depends only on the skid flop, never on OUT_READY.
    assign in_fire  = bus.IN_VALID && !s_valid;
    assign out_fire = m_valid && bus.OUT_READY;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (FLUSH) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (!m_valid || out_fire) begin
            m_valid <= s_valid || in_fire;
            s_valid <= 1'b0;
        end else if (in_fire) begin
            s_valid <= 1'b1;
        end
    end

    // Flush only kills valids; payload flops keep their contents.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            m <= '0;
            s <= '0;
        end else if (!FLUSH) begin
            if (!m_valid || out_fire) begin
                if (s_valid) begin
                    m <= s;
                end else if (in_fire) begin
                    m <= nxt;
                end
            end else if (in_fire) begin
                s <= nxt;
            end
        end
    end

    assign bus.IN_READY  = !s_valid;
    assign bus.OUT_VALID = m_valid;
    assign bus.IMMEDIATE = m.imm;
    assign bus.OUT_SEL   = m.sel;
    assign bus.OUT_TAG   = m.tag;
`ifdef IMM_TARGET_EN
    assign bus.TARGET    = m.tgt;
`endif
endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: XLEN=32 and XLEN=64 instances share stimulus
// and are checked every cycle against a queue-based reference model.
module tb_imm_gen_stage;
    localparam int TW = 16;

    logic        CLK     = 1'b0;
    logic        RESET_N = 1'b0;
    logic        FLUSH   = 1'b0;
    logic [63:0] pc64    = '0;
    int          vectors     = 0;
    int          miscompares = 0;
    bit          chk_en      = 1'b0;

    imm_gen_stage_if #(.XLEN(32), .TAG_W(TW)) bus();
    imm_gen_stage_if #(.XLEN(64), .TAG_W(TW)) bus64();

    assign bus64.IN_VALID    = bus.IN_VALID;
    assign bus64.INSTRUCTION = bus.INSTRUCTION;
    assign bus64.IMM_PICK    = bus.IMM_PICK;
    assign bus64.IN_TAG      = bus.IN_TAG;
    assign bus64.OUT_READY   = bus.OUT_READY;
`ifdef IMM_TARGET_EN
    assign bus.IN_PC   = pc64[31:0];
    assign bus64.IN_PC = pc64;
`endif

    imm_gen_stage #(.XLEN(32), .TAG_W(TW)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .FLUSH(FLUSH),
        .bus(bus.slave)
    );

    imm_gen_stage #(.XLEN(64), .TAG_W(TW)) dut64 (
        .CLK(CLK), .RESET_N(RESET_N), .FLUSH(FLUSH),
        .bus(bus64.slave)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [63:0]   imm;
        logic [2:0]    sel;
        logic [TW-1:0] tag;
        logic [63:0]   tgt;
    } ent_t;

    ent_t q32[$];
    ent_t q64[$];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic longint sx(longint raw, int bits);
        longint half;
        half = longint'(1) << (bits - 1);
        return (raw >= half) ? raw - 2 * half : raw;
    endfunction

    function automatic logic [63:0] ref_imm(logic [31:0] ins,
                                            logic [2:0] sel, int xlen);
        longint w;
        longint v;
        w = longint'({32'd0, ins});
        case (sel)
            3'd0: v = sx(w >> 20, 12);
            3'd1: v = sx(((w >> 25) << 5) + ((w >> 7) & 31), 12);
            3'd2: v = sx(w & 64'hFFFF_F000, 32);
            3'd3: v = sx(((w >> 31) << 12) + (((w >> 7) & 1) << 11)
                         + (((w >> 25) & 63) << 5)
                         + (((w >> 8) & 15) << 1), 13);
            3'd4: v = sx(((w >> 31) << 20) + (((w >> 12) & 255) << 12)
                         + (((w >> 20) & 1) << 11)
                         + (((w >> 21) & 1023) << 1), 21);
            3'd5: v = (w >> 15) & 31;
            3'd6: v = (w >> 20) & ((xlen == 64) ? 63 : 31);
            default: v = 0;
        endcase
        return (xlen == 64) ? 64'(v) : {32'd0, v[31:0]};
    endfunction

    function automatic ent_t mk(int xlen);
        ent_t e;
        logic [63:0] sum;
        e.imm = ref_imm(bus.INSTRUCTION, bus.IMM_PICK, xlen);
        e.sel = bus.IMM_PICK;
        e.tag = bus.IN_TAG;
        sum   = pc64 + e.imm;
        e.tgt = (xlen == 64) ? sum : {32'd0, sum[31:0]};
        return e;
    endfunction

    always @(negedge CLK) begin
        if (chk_en) begin
            bit r32, r64;
            chk("in_ready32", 64'(bus.IN_READY), 64'(q32.size() < 2));
            chk("out_valid32", 64'(bus.OUT_VALID), 64'(q32.size() > 0));
            if (q32.size() > 0) begin
                chk("imm32", 64'(bus.IMMEDIATE), q32[0].imm);
                chk("sel32", 64'(bus.OUT_SEL), 64'(q32[0].sel));
                chk("tag32", 64'(bus.OUT_TAG), 64'(q32[0].tag));
`ifdef IMM_TARGET_EN
                chk("tgt32", 64'(bus.TARGET), q32[0].tgt);
`endif
            end
            chk("in_ready64", 64'(bus64.IN_READY), 64'(q64.size() < 2));
            chk("out_valid64", 64'(bus64.OUT_VALID), 64'(q64.size() > 0));
            if (q64.size() > 0) begin
                chk("imm64", bus64.IMMEDIATE, q64[0].imm);
                chk("sel64", 64'(bus64.OUT_SEL), 64'(q64[0].sel));
                chk("tag64", 64'(bus64.OUT_TAG), 64'(q64[0].tag));
`ifdef IMM_TARGET_EN
                chk("tgt64", bus64.TARGET, q64[0].tgt);
`endif
            end
            r32 = (q32.size() < 2);
            r64 = (q64.size() < 2);
            if (FLUSH) begin
                q32.delete();
                q64.delete();
            end else begin
                if (bus.OUT_READY && q32.size() > 0) void'(q32.pop_front());
                if (bus.OUT_READY && q64.size() > 0) void'(q64.pop_front());
                if (bus.IN_VALID && r32) q32.push_back(mk(32));
                if (bus.IN_VALID && r64) q64.push_back(mk(64));
            end
        end
    end

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(bit v, logic [31:0] ins, logic [2:0] sel,
                         logic [TW-1:0] tag);
        bus.IN_VALID    = v;
        bus.INSTRUCTION = ins;
        bus.IMM_PICK    = sel;
        bus.IN_TAG      = tag;
    endtask

    task automatic one(logic [31:0] ins, logic [2:0] sel,
                       logic [63:0] e32, logic [63:0] e64);
        drive(1'b1, ins, sel, TW'(ins));
        step;
        chk("dir_valid", 64'(bus.OUT_VALID), 64'd1);
        chk("dir_imm32", 64'(bus.IMMEDIATE), e32);
        chk("dir_imm64", bus64.IMMEDIATE, e64);
        bus.IN_VALID = 1'b0;
        step;
    endtask

    task automatic rand_cycles(int n);
        for (int i = 0; i < n; i++) begin
            bus.IN_VALID    = ($urandom_range(0, 9) < 7);
            bus.INSTRUCTION = $urandom;
            bus.IMM_PICK    = 3'($urandom_range(0, 7));
            bus.IN_TAG      = TW'($urandom);
            bus.OUT_READY   = ($urandom_range(0, 9) < 6);
            FLUSH           = ($urandom_range(0, 31) == 0);
            pc64            = {$urandom, $urandom};
            step;
        end
        FLUSH = 1'b0;
    endtask

    initial begin
        #1000000;
        miscompares++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        drive(1'b0, 32'd0, 3'd0, '0);
        bus.OUT_READY = 1'b0;

        chk("model_i", ref_imm(32'hFFF00093, 3'd0, 32), 64'hFFFF_FFFF);
        chk("model_b", ref_imm(32'hFE000EE3, 3'd3, 32), 64'hFFFF_FFFC);
        chk("model_z", ref_imm(32'h000FD073, 3'd5, 32), 64'h1F);
        chk("model_u64", ref_imm(32'h800000B7, 3'd2, 64),
            64'hFFFF_FFFF_8000_0000);
        chk("model_sh64", ref_imm(32'h03F01093, 3'd6, 64), 64'h3F);
        chk("model_j", ref_imm(32'h0080006F, 3'd4, 32), 64'h8);

        #12;
        chk("rst_out_valid", 64'(bus.OUT_VALID), 64'd0);
        chk("rst_in_ready", 64'(bus.IN_READY), 64'd1);
        chk("rst_imm", 64'(bus.IMMEDIATE), 64'd0);
        chk("rst_sel", 64'(bus.OUT_SEL), 64'd0);
        chk("rst_tag", 64'(bus.OUT_TAG), 64'd0);
        chk("rst_imm64", bus64.IMMEDIATE, 64'd0);
`ifdef IMM_TARGET_EN
        chk("rst_tgt", 64'(bus.TARGET), 64'd0);
`endif
        RESET_N = 1'b1;
        chk_en  = 1'b1;
        step;

        bus.OUT_READY = 1'b1;
        one(32'hFFF00093, 3'd0, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        one(32'hFE000EE3, 3'd3, 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC);
        one(32'h000FD073, 3'd5, 64'h1F, 64'h1F);
        one(32'h800000B7, 3'd2, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000);
        one(32'h03F01093, 3'd6, 64'h1F, 64'h3F);
        one(32'h03F01093, 3'd7, 64'h0, 64'h0);
`ifdef IMM_TARGET_EN
        pc64 = 64'h100;
        drive(1'b1, 32'h0080006F, 3'd4, '0);
        step;
        chk("tgt_j32", 64'(bus.TARGET), 64'h108);
        chk("tgt_j64", bus64.TARGET, 64'h108);
        chk("imm_j32", 64'(bus.IMMEDIATE), 64'h8);
        bus.IN_VALID = 1'b0;
        step;
`endif

        bus.OUT_READY = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            drive(1'b1, 32'h00100093, 3'd0, TW'(t));
            step;
        end
        chk("bp_in_ready", 64'(bus.IN_READY), 64'd0);
        chk("bp_tag1", 64'(bus.OUT_TAG), 64'd1);
        bus.OUT_READY = 1'b1;
        step;
        chk("bp_tag2", 64'(bus.OUT_TAG), 64'd2);
        step;
        chk("bp_tag3", 64'(bus.OUT_TAG), 64'd3);
        bus.IN_VALID = 1'b0;
        step;
        chk("bp_drained", 64'(bus.OUT_VALID), 64'd0);

        bus.OUT_READY = 1'b0;
        drive(1'b1, 32'h00A00093, 3'd0, TW'(10));
        step;
        drive(1'b1, 32'h00B00093, 3'd0, TW'(11));
        step;
        drive(1'b1, 32'h00C00093, 3'd0, TW'(12));
        FLUSH = 1'b1;
        step;
        chk("fl_out_valid", 64'(bus.OUT_VALID), 64'd0);
        chk("fl_in_ready", 64'(bus.IN_READY), 64'd1);
        chk("fl_tag_held", 64'(bus.OUT_TAG), 64'd10);
        FLUSH = 1'b0;
        bus.IN_VALID  = 1'b0;
        bus.OUT_READY = 1'b1;
        step;
        chk("fl_no_ghost", 64'(bus.OUT_VALID), 64'd0);

        rand_cycles(3000);

        bus.OUT_READY = 1'b0;
        drive(1'b1, 32'h12345093, 3'd0, TW'(5));
        step;
        chk_en = 1'b0;
        #2;
        RESET_N = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(bus.OUT_VALID), 64'd0);
        chk("mid_rst_ready", 64'(bus.IN_READY), 64'd1);
        chk("mid_rst_imm", 64'(bus.IMMEDIATE), 64'd0);
        chk("mid_rst_valid64", 64'(bus64.OUT_VALID), 64'd0);
        q32.delete();
        q64.delete();
        bus.IN_VALID = 1'b0;
        step;
        step;
        RESET_N = 1'b1;
        chk_en  = 1'b1;

        rand_cycles(300);

        bus.IN_VALID  = 1'b0;
        bus.OUT_READY = 1'b1;
        repeat (4) step;
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
